codec_cfg_sequencer: RTL and testbench
======================================

Name: codec_cfg_sequencer

Overview:
- Sequences the audio codec's power-up register writes through the existing i2c_write block, then shares that writer between the init table and one runtime requester (volume/mute updates).
- Walks a fixed table of (register, data) pairs, issues one i2c_write transaction per entry, inserts a settle gap between entries, then reports init_done.
- Sits between top-level control and i2c_write; it is the only driver of i2c_write's write/addr/register/data inputs.

Parameters:
- NUM_ENTRIES, 11: number of init table entries (1..255).
- DEV_ADDR, 8'h34: 8-bit I2C address byte (7-bit address plus R/W=0) placed on i2c_addr.
- GAP_CYCLES, 1000: sys_clk cycles idled after each init write; 0 means no gap.
- TIMEOUT_CYCLES, 1000000: maximum wait for i2c_done. Used only with the optional feature.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- start  in  1  level; sampled in IDLE/READY/ERR; begins or reruns the init sequence.
- busy  out  1  high in any state except IDLE, READY and ERR.
- init_done  out  1  high in READY.
- err  out  1  sticky timeout flag.
- rt_req  in  1  runtime write request; level, held until rt_ack.
- rt_reg  in  8  runtime register index.
- rt_data  in  8  runtime data.
- rt_ack  out  1  one-cycle pulse when the runtime write completes.
- i2c_write  out  1  one-cycle request pulse to i2c_write.
- i2c_addr  out  8  device address byte.
- i2c_register  out  8  register byte.
- i2c_data  out  8  data byte.
- i2c_done  in  1  one-cycle completion pulse from i2c_write.

Behaviour:
- Reset (async, any state, including mid-transaction) sets:
  - state IDLE, idx 0, gap/timeout counters 0;
  - busy, init_done, err, rt_ack, i2c_write all 0;
  - i2c_addr = DEV_ADDR, i2c_register = 0, i2c_data = 0.
- States: IDLE, LOAD, REQ, WAIT, GAP, READY, RT_REQ, RT_WAIT, ERR.
- IDLE:
  - start=1 moves to LOAD with idx=0.
  - rt_req is ignored (no ack) until READY.
- LOAD: registers the ROM entry idx into i2c_register/i2c_data, then goes to REQ.
- REQ: i2c_write=1 for exactly this cycle, then goes to WAIT.
- Operand stability: i2c_addr, i2c_register and i2c_data stay stable from LOAD until i2c_done.
- WAIT, on i2c_done:
  - if idx==NUM_ENTRIES-1, go to READY next cycle (no trailing gap);
  - else if GAP_CYCLES==0, idx+1 and go to LOAD;
  - else go to GAP.
- GAP: counts GAP_CYCLES cycles, then idx+1 and goes to LOAD.
- Latency:
  - start seen at cycle N: i2c_write=1 at N+2.
  - Last i2c_done at cycle M: init_done=1 at M+1.
- READY, start and rt_req both high: start wins. Clear init_done, idx=0, go to LOAD; rt_req stays pending.
- READY, rt_req=1 (start low): latch rt_reg/rt_data into i2c_register/i2c_data, go to RT_REQ. init_done stays high throughout runtime writes.
- RT_REQ: i2c_write=1 for one cycle, then goes to RT_WAIT.
- RT_WAIT, on i2c_done: rt_ack=1 for one cycle, return to READY.
  - The requester must drop rt_req within one cycle of ack, otherwise a second write is issued.
- start while busy is ignored.
- i2c_done outside WAIT/RT_WAIT is ignored.
- ERR: busy=0, init_done=0. start clears err and goes to LOAD with idx=0.
- Widths: idx is 8 bit and never exceeds NUM_ENTRIES-1. The gap counter is 32 bit and saturates.

Optional Feature:
- Macro: CODEC_CFG_TIMEOUT_EN.
- Defined:
  - A 32-bit counter runs in WAIT/RT_WAIT and clears on state entry.
  - Reaching TIMEOUT_CYCLES without i2c_done sets err=1 and moves to ERR.
  - On an RT_WAIT timeout, no rt_ack is issued.
  - If i2c_done arrives in the same cycle the limit is reached, done wins.
- Undefined: no counter, err tied to 0, WAIT/RT_WAIT wait indefinitely.

Decomposition:
- Package codec_cfg_pkg holds:
  - state enum typedef;
  - cfg_entry_t struct {reg[7:0], data[7:0]};
  - WM8731 register index constants (reset, left/right line in, headphone, analog path, digital path, power down, interface format, sampling, active);
  - DEFAULT_DEV_ADDR.
- One sub-module: codec_cfg_rom, a combinational case table mapping idx to cfg_entry_t. Out-of-range idx returns {0,0}.

Test Plan:
- Reset, pulse start, bench i2c_done 20 cycles after each i2c_write, GAP_CYCLES=4, NUM_ENTRIES=3:
  - exactly 3 i2c_write pulses carrying table entries 0,1,2 in order;
  - ≥4 idle cycles between done and the next write;
  - init_done rises 1 cycle after the 3rd done.
- In READY, rt_req with rt_reg=8'h00, rt_data=8'h17:
  - i2c_write pulse with i2c_addr=8'h34, i2c_register=8'h00, i2c_data=8'h17;
  - rt_ack exactly 1 cycle after done;
  - init_done stays 1.
- In READY, raise start and rt_req in the same cycle:
  - init sequence reruns first (init_done drops);
  - runtime write is issued only after init_done returns.
- Assert sys_rst_n low during WAIT of entry 1, release:
  - all outputs at reset values immediately (async);
  - a later start restarts from entry 0.
- With CODEC_CFG_TIMEOUT_EN and TIMEOUT_CYCLES=50, never return i2c_done:
  - err=1 at cycle 50 of WAIT, busy=0;
  - start clears err and re-issues entry 0.
- rt_req asserted in IDLE before init: no i2c_write and no rt_ack until init completes; then the write is serviced.

Source files
------------

// File: rtl/codec_cfg_pkg.sv
// Shared types and constants for the codec configuration sequencer.
// Holds the FSM state encoding, the init table entry layout, the WM8731
// register indices used by the init table and the default device address.
package codec_cfg_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        REQ,
        WAIT,
        GAP,
        READY,
        RT_REQ,
        RT_WAIT,
        ERR
    } state_t;

    typedef struct packed {
        logic [7:0] reg_addr;
        logic [7:0] data;
    } cfg_entry_t;

    // WM8731 register indices
    localparam logic [7:0] REG_LLINE_IN     = 8'h00;
    localparam logic [7:0] REG_RLINE_IN     = 8'h01;
    localparam logic [7:0] REG_LHP_OUT      = 8'h02;
    localparam logic [7:0] REG_RHP_OUT      = 8'h03;
    localparam logic [7:0] REG_ANALOG_PATH  = 8'h04;
    localparam logic [7:0] REG_DIGITAL_PATH = 8'h05;
    localparam logic [7:0] REG_POWER_DOWN   = 8'h06;
    localparam logic [7:0] REG_INTERFACE    = 8'h07;
    localparam logic [7:0] REG_SAMPLING     = 8'h08;
    localparam logic [7:0] REG_ACTIVE       = 8'h09;
    localparam logic [7:0] REG_RESET        = 8'h0F;

    // 7-bit address 0x1A with R/W=0
    localparam logic [7:0] DEFAULT_DEV_ADDR = 8'h34;

endpackage

// File: rtl/codec_cfg_rom.sv
// Power-up register table for the codec. Pure combinational lookup from
// entry index to (register, data); indices past the table return zeros.
module codec_cfg_rom
    import codec_cfg_pkg::*;
(
    input  logic [7:0] idx,
    output cfg_entry_t entry
);

    // Table lookup; reset first, activate last so the codec powers up configured
    always_comb begin
        entry = '{reg_addr: 8'h00, data: 8'h00};
        case (idx)
            8'd0:    entry = '{reg_addr: REG_RESET,        data: 8'h00};
            8'd1:    entry = '{reg_addr: REG_LLINE_IN,     data: 8'h17};
            8'd2:    entry = '{reg_addr: REG_RLINE_IN,     data: 8'h17};
            8'd3:    entry = '{reg_addr: REG_LHP_OUT,      data: 8'h79};
            8'd4:    entry = '{reg_addr: REG_RHP_OUT,      data: 8'h79};
            8'd5:    entry = '{reg_addr: REG_ANALOG_PATH,  data: 8'h12};
            8'd6:    entry = '{reg_addr: REG_DIGITAL_PATH, data: 8'h00};
            8'd7:    entry = '{reg_addr: REG_POWER_DOWN,   data: 8'h00};
            8'd8:    entry = '{reg_addr: REG_INTERFACE,    data: 8'h42};
            8'd9:    entry = '{reg_addr: REG_SAMPLING,     data: 8'h00};
            8'd10:   entry = '{reg_addr: REG_ACTIVE,       data: 8'h01};
            default: entry = '{reg_addr: 8'h00, data: 8'h00};
        endcase
    end

endmodule

// File: rtl/codec_cfg_sequencer.sv
// Codec configuration sequencer: walks the init table through i2c_write,
// inserting a settle gap between entries, then arbitrates i2c_write for one
// runtime requester (volume/mute updates).
// Optional build macro CODEC_CFG_TIMEOUT_EN adds an i2c_done watchdog that
// drops into ERR and raises the sticky err flag.
//
// Handshakes:
//   i2c_write is a one-cycle request; operands are held from LOAD (or the
//   READY latch) until the one-cycle i2c_done pulse. rt_req is a level held
//   by the requester until rt_ack, which pulses for one cycle the cycle after
//   i2c_done; rt_req must be low the cycle after rt_ack.
module codec_cfg_sequencer
    import codec_cfg_pkg::*;
#(
    parameter int         NUM_ENTRIES    = 11,
    parameter logic [7:0] DEV_ADDR       = DEFAULT_DEV_ADDR,
    parameter int         GAP_CYCLES     = 1000,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       start,
    output logic       busy,
    output logic       init_done,
    output logic       err,
    input  logic       rt_req,
    input  logic [7:0] rt_reg,
    input  logic [7:0] rt_data,
    output logic       rt_ack,
    output logic       i2c_write,
    output logic [7:0] i2c_addr,
    output logic [7:0] i2c_register,
    output logic [7:0] i2c_data,
    input  logic       i2c_done
);

    localparam logic [7:0]  LAST_IDX = 8'(NUM_ENTRIES - 1);
    localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);

    state_t      state, state_next;
    logic [7:0]  idx, idx_next;
    logic [31:0] gap_cnt, gap_next;
    logic        load_rom, load_rt, ack_next, set_err, clr_err;
    logic        err_q;
    logic        timeout_hit;
    cfg_entry_t  rom_entry;

    codec_cfg_rom u_rom (
        .idx   (idx),
        .entry (rom_entry)
    );

`ifdef CODEC_CFG_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] to_cnt;

    // Watchdog: counts cycles spent waiting for i2c_done, restarts on each wait
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            to_cnt <= 32'd0;
        end else if (state == WAIT || state == RT_WAIT) begin
            if (to_cnt != '1) to_cnt <= to_cnt + 32'd1;
        end else begin
            to_cnt <= 32'd0;
        end
    end

    assign timeout_hit = (state == WAIT || state == RT_WAIT) && (to_cnt >= TIMEOUT_LAST);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
    assign timeout_hit        = 1'b0;
`endif

    // Next-state logic; i2c_done is checked before the watchdog so done wins a tie
    always_comb begin
        state_next = state;
        idx_next   = idx;
        gap_next   = gap_cnt;
        load_rom   = 1'b0;
        load_rt    = 1'b0;
        ack_next   = 1'b0;
        set_err    = 1'b0;
        clr_err    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    idx_next   = 8'd0;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                load_rom   = 1'b1;
                state_next = REQ;
            end
            REQ: state_next = WAIT;
            WAIT: begin
                if (i2c_done) begin
                    if (idx == LAST_IDX) begin
                        state_next = READY;
                    end else if (GAP_CYCLES == 0) begin
                        idx_next   = idx + 8'd1;
                        state_next = LOAD;
                    end else begin
                        gap_next   = 32'd0;
                        state_next = GAP;
                    end
                end else if (timeout_hit) begin
                    set_err    = 1'b1;
                    state_next = ERR;
                end
            end
            GAP: begin
                if (gap_cnt >= GAP_LAST) begin
                    gap_next   = 32'd0;
                    idx_next   = idx + 8'd1;
                    state_next = LOAD;
                end else if (gap_cnt != '1) begin
                    gap_next = gap_cnt + 32'd1;
                end
            end
            READY: begin
                // start wins over a pending runtime request; rt_ack high means
                // the requester is still dropping its previous request
                if (start) begin
                    idx_next   = 8'd0;
                    state_next = LOAD;
                end else if (rt_req && !rt_ack) begin
                    load_rt    = 1'b1;
                    state_next = RT_REQ;
                end
            end
            RT_REQ: state_next = RT_WAIT;
            RT_WAIT: begin
                if (i2c_done) begin
                    ack_next   = 1'b1;
                    state_next = READY;
                end else if (timeout_hit) begin
                    set_err    = 1'b1;
                    state_next = ERR;
                end
            end
            ERR: begin
                if (start) begin
                    clr_err    = 1'b1;
                    idx_next   = 8'd0;
                    state_next = LOAD;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, table index, gap counter and the registered ack/err flags
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state   <= IDLE;
            idx     <= 8'd0;
            gap_cnt <= 32'd0;
            rt_ack  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_next;
            idx     <= idx_next;
            gap_cnt <= gap_next;
            rt_ack  <= ack_next;
            if (set_err)      err_q <= 1'b1;
            else if (clr_err) err_q <= 1'b0;
        end
    end

    // Operand registers for i2c_write; only loaded in LOAD or on a READY accept
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            i2c_addr     <= DEV_ADDR;
            i2c_register <= 8'h00;
            i2c_data     <= 8'h00;
        end else begin
            i2c_addr <= DEV_ADDR;
            if (load_rom) begin
                i2c_register <= rom_entry.reg_addr;
                i2c_data     <= rom_entry.data;
            end else if (load_rt) begin
                i2c_register <= rt_reg;
                i2c_data     <= rt_data;
            end
        end
    end

    assign busy      = !(state inside {IDLE, READY, ERR});
    assign init_done = state inside {READY, RT_REQ, RT_WAIT};
    assign i2c_write = (state == REQ) || (state == RT_REQ);
    assign err       = err_q;

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// Bench for codec_cfg_sequencer with a 3-entry table and a 4-cycle gap.
// A transaction-level model predicts busy/init_done/rt_ack/err and the
// content of every i2c_write; a responder returns i2c_done 20 cycles after
// each write. Build with CODEC_CFG_TIMEOUT_EN to add the watchdog scenario.
module tb_codec_cfg_sequencer;

    localparam int NUM_ENTRIES    = 3;
    localparam int GAP_CYCLES     = 4;
    localparam int TIMEOUT_CYCLES = 50;
    localparam int DONE_DELAY     = 20;
    localparam int W              = 24;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       start     = 1'b0;
    logic       rt_req    = 1'b0;
    logic [7:0] rt_reg    = 8'h00;
    logic [7:0] rt_data   = 8'h00;
    logic       i2c_done  = 1'b0;
    logic       busy, init_done, err, rt_ack, i2c_write;
    logic [7:0] i2c_addr, i2c_register, i2c_data;

    codec_cfg_sequencer #(
        .NUM_ENTRIES    (NUM_ENTRIES),
        .DEV_ADDR       (8'h34),
        .GAP_CYCLES     (GAP_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .start        (start),
        .busy         (busy),
        .init_done    (init_done),
        .err          (err),
        .rt_req       (rt_req),
        .rt_reg       (rt_reg),
        .rt_data      (rt_data),
        .rt_ack       (rt_ack),
        .i2c_write    (i2c_write),
        .i2c_addr     (i2c_addr),
        .i2c_register (i2c_register),
        .i2c_data     (i2c_data),
        .i2c_done     (i2c_done)
    );

    // Clock
    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected init table contents (addr, register, data)
    logic [W-1:0] init_table [NUM_ENTRIES] = '{
        {8'h34, 8'h0F, 8'h00},
        {8'h34, 8'h00, 8'h17},
        {8'h34, 8'h01, 8'h17}
    };

    // Scoreboard / model state
    logic [W-1:0] exp_q[$];
    logic [W-1:0] out_word;
    bit  init_running, model_done, model_err, ack_due;
    bit  out_valid, out_is_rt, out_last, out_first, exp_busy, init_done_d;
    int  cyc = 0, out_cyc = 0, last_done_cyc = 0, start_cyc = 0, ready_cyc = 0;
    int  resp_cnt = 0;
    bit  resp_en = 1'b1;
    int  write_cyc[$];
`ifdef CODEC_CFG_TIMEOUT_EN
    bit  err_d;
    int  err_cyc = 0;
`endif

    // Responder, write scoreboard and per-cycle output model
    always @(negedge sys_clk) begin
        cyc++;
        if (!sys_rst_n) begin
            init_running = 0; model_done = 0; model_err = 0; ack_due = 0;
            out_valid = 0; init_done_d = 0; resp_cnt = 0; i2c_done = 1'b0;
            exp_q.delete();
`ifdef CODEC_CFG_TIMEOUT_EN
            err_d = 0;
`endif
        end else begin
            // i2c_done for this cycle
            i2c_done = 1'b0;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) i2c_done = 1'b1;
            end

            if (i2c_write) begin
                write_cyc.push_back(cyc);
                out_is_rt = 0;
                out_word  = {i2c_addr, i2c_register, i2c_data};
                if (init_running) begin
                    check("init_write_expected", exp_q.size() > 0, 1'b1);
                    if (exp_q.size() > 0) begin
                        out_first = (exp_q.size() == NUM_ENTRIES);
                        out_word  = exp_q.pop_front();
                        out_last  = (exp_q.size() == 0);
                        check("init_write", {i2c_addr, i2c_register, i2c_data}, out_word);
                        if (!out_first)
                            check("gap_idle_cycles", (cyc - last_done_cyc - 1) >= GAP_CYCLES, 1'b1);
                    end
                end else if (model_done && rt_req) begin
                    out_is_rt = 1;
                    out_word  = {8'h34, rt_reg, rt_data};
                    check("rt_write", {i2c_addr, i2c_register, i2c_data}, out_word);
                end else begin
                    check("unexpected_write", i2c_write, 1'b0);
                end
                out_valid = 1;
                out_cyc   = cyc;
            end

            exp_busy = init_running || (out_valid && out_is_rt);
            check("busy", busy, exp_busy);
            check("init_done", init_done, model_done);
            check("rt_ack", rt_ack, ack_due);
            check("err", err, model_err);
            check("i2c_addr", i2c_addr, 8'h34);
            if (out_valid)
                check("operand_stable", {i2c_addr, i2c_register, i2c_data}, out_word);

            if (init_done && !init_done_d) ready_cyc = cyc;
            init_done_d = init_done;
`ifdef CODEC_CFG_TIMEOUT_EN
            if (err && !err_d) err_cyc = cyc;
            err_d = err;
`endif

            // Model update for the next cycle
            ack_due = 0;
            if (out_valid && i2c_done) begin
                if (out_is_rt) begin
                    ack_due = 1;
                end else if (out_last) begin
                    init_running = 0;
                    model_done   = 1;
                end
                out_valid     = 0;
                last_done_cyc = cyc;
            end
`ifdef CODEC_CFG_TIMEOUT_EN
            else if (out_valid && cyc == out_cyc + TIMEOUT_CYCLES) begin
                model_err    = 1;
                model_done   = 0;
                init_running = 0;
                out_valid    = 0;
            end
`endif
            if (start && !exp_busy) begin
                init_running = 1;
                model_done   = 0;
                model_err    = 0;
                start_cyc    = cyc;
                exp_q.delete();
                for (int i = 0; i < NUM_ENTRIES; i++) exp_q.push_back(init_table[i]);
            end

            if (i2c_write && resp_en) resp_cnt = DONE_DELAY;
        end
    end

    // Driver tasks
    task automatic pulse_start();
        @(posedge sys_clk); #1 start = 1'b1;
        @(posedge sys_clk); #1 start = 1'b0;
    endtask

    task automatic wait_init_done(input string name, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge sys_clk); #1;
            if (init_done) begin seen = 1; break; end
        end
        check(name, seen, 1'b1);
    endtask

    task automatic wait_rt_ack(input string name, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge sys_clk); #1;
            if (rt_ack) begin seen = 1; rt_req = 1'b0; break; end
        end
        rt_req = 1'b0;
        check(name, seen, 1'b1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"},      busy,         1'b0);
        check({tag, "_init_done"}, init_done,    1'b0);
        check({tag, "_err"},       err,          1'b0);
        check({tag, "_rt_ack"},    rt_ack,       1'b0);
        check({tag, "_i2c_write"}, i2c_write,    1'b0);
        check({tag, "_i2c_addr"},  i2c_addr,     8'h34);
        check({tag, "_i2c_reg"},   i2c_register, 8'h00);
        check({tag, "_i2c_data"},  i2c_data,     8'h00);
    endtask

    initial begin
        bit seen;
        repeat (3) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        check_reset_values("por");

        // Runtime request while still in IDLE: must wait for init
        @(posedge sys_clk); #1;
        rt_reg = 8'h00; rt_data = 8'h17; rt_req = 1'b1;
        repeat (10) @(posedge sys_clk);
        #1 check("idle_rt_no_write", write_cyc.size(), 0);

        pulse_start();
        wait_init_done("init1_done_seen", 200);
        check("init1_write_count", write_cyc.size(), 3);
        if (write_cyc.size() == 3) begin
            check("lat_start_to_write", write_cyc[0] - start_cyc, 2);
            check("lat_write0_to_write1", write_cyc[1] - write_cyc[0], 26);
            check("lat_write0_to_write2", write_cyc[2] - write_cyc[0], 52);
        end
        check("lat_start_to_ready", ready_cyc - start_cyc, 75);
        wait_rt_ack("rt1_ack_seen", 60);
        check("rt1_total_writes", write_cyc.size(), 4);
        @(negedge sys_clk); #1;
        check("rt1_init_done_held", init_done, 1'b1);

        // start and rt_req together in READY: init reruns first
        write_cyc.delete();
        @(posedge sys_clk); #1;
        rt_reg = 8'h05; rt_data = 8'h0A; rt_req = 1'b1; start = 1'b1;
        @(posedge sys_clk); #1 start = 1'b0;
        @(negedge sys_clk); #1;
        check("rerun_init_done_low", init_done, 1'b0);
        wait_init_done("init2_done_seen", 200);
        check("init2_write_count", write_cyc.size(), 3);
        wait_rt_ack("rt2_ack_seen", 60);
        check("rt2_total_writes", write_cyc.size(), 4);
        check("rt2_reg_held", i2c_register, 8'h05);

        // Asynchronous reset during WAIT of entry 1
        write_cyc.delete();
        pulse_start();
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge sys_clk); #1;
            if (write_cyc.size() >= 2) begin seen = 1; break; end
        end
        check("entry1_write_seen", seen, 1'b1);
        repeat (5) @(posedge sys_clk);
        #3 sys_rst_n = 1'b0;
        #1 check_reset_values("async_rst");
        repeat (2) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        write_cyc.delete();
        pulse_start();
        wait_init_done("init3_done_seen", 200);
        check("init3_write_count", write_cyc.size(), 3);
        check("init3_last_reg", i2c_register, 8'h01);
        check("init3_last_data", i2c_data, 8'h17);

`ifdef CODEC_CFG_TIMEOUT_EN
        // Watchdog: no i2c_done ever returned
        resp_en = 1'b0;
        write_cyc.delete();
        pulse_start();
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge sys_clk); #1;
            if (err) begin seen = 1; break; end
        end
        check("timeout_err_seen", seen, 1'b1);
        if (write_cyc.size() > 0) check("timeout_err_cycle", err_cyc - write_cyc[0], 51);
        check("timeout_busy_low", busy, 1'b0);
        resp_en = 1'b1;
        write_cyc.delete();
        pulse_start();
        wait_init_done("init4_done_seen", 200);
        check("init4_write_count", write_cyc.size(), 3);
        check("init4_err_cleared", err, 1'b0);
`endif

        repeat (5) @(posedge sys_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
